// File: rtl/button_press_decoder.sv
// Turns the debounced button level into press/release/click/long/repeat pulses and a press count.
// Define BTN_DECODER_REPEAT_EN to enable auto-repeat pulses while a long press is held.
module button_press_decoder #(
  parameter int unsigned LONG_CYCLES   = 25000000,
  parameter int unsigned REPEAT_CYCLES = 5000000,
  parameter int unsigned CNT_W         = 26
) (
  input  logic       c50M,
  input  logic       nReset,
  input  logic       ButtonIn,
  output logic       Held,
  output logic       PressPulse,
  output logic       ReleasePulse,
  output logic       ClickPulse,
  output logic       LongPulse,
  output logic       RepeatPulse,
  output logic [7:0] PressCount
);

  // state | meaning
  // IDLE  | button released, waiting for btn_q
  // SHORT | pressed, hold shorter than LONG_CYCLES
  // LONG  | pressed, long press already reported
  typedef enum logic [1:0] {IDLE, SHORT, LONG} state_t;

  if (LONG_CYCLES < 2 || REPEAT_CYCLES < 2 ||
      64'(LONG_CYCLES) > ((64'd1 << CNT_W) - 64'd1) ||
      64'(REPEAT_CYCLES) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_params
    $error("button_press_decoder: LONG_CYCLES/REPEAT_CYCLES out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] LONG_CMP = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
`ifdef BTN_DECODER_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_CMP  = CNT_W'(REPEAT_CYCLES);
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       pcnt_q, pcnt_d;
  logic             btn_q;
  logic             held_q, held_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic             click_q, click_d;
  logic             long_q, long_d;
  logic             rep_q, rep_d;

  always_ff @(posedge c50M or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      btn_q   <= 1'b0;
      held_q  <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      click_q <= 1'b0;
      long_q  <= 1'b0;
      rep_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      btn_q   <= ButtonIn;
      held_q  <= held_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      click_q <= click_d;
      long_q  <= long_d;
      rep_q   <= rep_d;
    end
  end

  // Release is checked first in every pressed state so it beats a coincident threshold.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    click_d = 1'b0;
    long_d  = 1'b0;
    rep_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_q) begin
          state_d = SHORT;
          press_d = 1'b1;
          pcnt_d  = pcnt_q + 8'd1;
          cnt_d   = CNT_ONE;
        end
      end
      SHORT: begin
        if (!btn_q) begin
          state_d = IDLE;
          rel_d   = 1'b1;
          click_d = 1'b1;
          cnt_d   = '0;
        end else if (cnt_q == LONG_CMP) begin
          state_d = LONG;
          long_d  = 1'b1;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      LONG: begin
        if (!btn_q) begin
          state_d = IDLE;
          rel_d   = 1'b1;
          cnt_d   = '0;
        end else begin
`ifdef BTN_DECODER_REPEAT_EN
          if (cnt_q == REP_CMP) begin
            rep_d = 1'b1;
            cnt_d = CNT_ONE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    held_d = (state_d != IDLE);
  end

  assign Held         = held_q;
  assign PressPulse   = press_q;
  assign ReleasePulse = rel_q;
  assign ClickPulse   = click_q;
  assign LongPulse    = long_q;
  assign RepeatPulse  = rep_q;
  assign PressCount   = pcnt_q;

endmodule

// File: tb/tb_button_press_decoder.sv
// Directed bench for button_press_decoder: expected pulses are queued at stimulus time and
// matched in order by a negedge monitor. Honours BTN_DECODER_REPEAT_EN for repeat expectations.
module tb_button_press_decoder;

  localparam int LONG = 10;
  localparam int REP  = 4;

  localparam logic [4:0] P_PRESS = 5'b10000;
  localparam logic [4:0] P_REL   = 5'b01000;
  localparam logic [4:0] P_CLICK = 5'b00100;
  localparam logic [4:0] P_LONG  = 5'b00010;
  localparam logic [4:0] P_REP   = 5'b00001;

  logic       c50M = 1'b0;
  logic       nReset = 1'b0;
  logic       ButtonIn = 1'b0;
  logic       Held, PressPulse, ReleasePulse, ClickPulse, LongPulse, RepeatPulse;
  logic [7:0] PressCount;

  typedef struct packed {
    logic [31:0] cyc;
    logic [4:0]  pulses;
    logic [7:0]  cnt;
  } ev_t;

  ev_t        exp_q[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         held_cycles = 0;
  logic [7:0] exp_cnt = 8'd0;

  button_press_decoder #(
    .LONG_CYCLES(LONG),
    .REPEAT_CYCLES(REP),
    .CNT_W(8)
  ) dut (
    .c50M(c50M),
    .nReset(nReset),
    .ButtonIn(ButtonIn),
    .Held(Held),
    .PressPulse(PressPulse),
    .ReleasePulse(ReleasePulse),
    .ClickPulse(ClickPulse),
    .LongPulse(LongPulse),
    .RepeatPulse(RepeatPulse),
    .PressCount(PressCount)
  );

  always #10 c50M = ~c50M;
  always @(posedge c50M) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [4:0] p);
    ev_t e;
    e.cyc    = 32'(c);
    e.pulses = p;
    e.cnt    = exp_cnt;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string tag);
    repeat (6) @(negedge c50M);
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  always @(negedge c50M) begin
    logic [4:0] obs;
    ev_t        e;
    obs = {PressPulse, ReleasePulse, ClickPulse, LongPulse, RepeatPulse};
    if (Held === 1'b1) held_cycles++;
    if (obs !== 5'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 32'(obs), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_kind", 32'(obs), 32'(e.pulses));
        chk("pulse_cycle", 32'(cyc), e.cyc);
        chk("press_count", 32'(PressCount), 32'(e.cnt));
      end
    end
  end

  initial begin
    int h0;
    int p;

    // reset and idle
    repeat (3) @(negedge c50M);
    chk("reset_outputs", {23'd0, Held, PressPulse, ReleasePulse, ClickPulse, LongPulse,
                          RepeatPulse, PressCount}, 32'd0);
    nReset = 1'b1;
    repeat (20) @(negedge c50M);
    chk("idle_held", 32'(Held), 32'd0);
    chk("idle_count", 32'(PressCount), 32'd0);

    // short click, 3 cycles high
    h0 = held_cycles;
    ButtonIn = 1'b1;
    exp_cnt++;
    push(cyc + 2, P_PRESS);
    repeat (3) @(negedge c50M);
    ButtonIn = 1'b0;
    push(cyc + 2, P_REL | P_CLICK);
    drain("click_drain");
    chk("click_held_cycles", 32'(held_cycles - h0), 32'd3);

    // 30-cycle hold: long press, repeats when enabled
    ButtonIn = 1'b1;
    exp_cnt++;
    p = cyc + 2;
    push(p, P_PRESS);
    push(p + LONG, P_LONG);
`ifdef BTN_DECODER_REPEAT_EN
    for (int k = 1; k <= 4; k++) push(p + LONG + k * REP, P_REP);
`endif
    repeat (30) @(negedge c50M);
    ButtonIn = 1'b0;
    push(cyc + 2, P_REL);
    drain("long_drain");

    // release lands exactly on the long threshold: release wins
    ButtonIn = 1'b1;
    exp_cnt++;
    p = cyc + 2;
    push(p, P_PRESS);
    repeat (LONG) @(negedge c50M);
    ButtonIn = 1'b0;
    chk("threshold_release_cycle", 32'(cyc + 2), 32'(p + LONG));
    push(cyc + 2, P_REL | P_CLICK);
    drain("threshold_drain");

    // 257 minimum presses back to back, count wraps
    exp_cnt = 8'd0;
    nReset = 1'b0;
    @(negedge c50M);
    nReset = 1'b1;
    @(negedge c50M);
    for (int i = 0; i < 257; i++) begin
      ButtonIn = 1'b1;
      exp_cnt++;
      push(cyc + 2, P_PRESS);
      push(cyc + 3, P_REL | P_CLICK);
      @(negedge c50M);
      ButtonIn = 1'b0;
      @(negedge c50M);
    end
    drain("wrap_drain");
    chk("wrap_count", 32'(PressCount), 32'd1);

    // reset in the middle of a hold, button stays high
    ButtonIn = 1'b1;
    exp_cnt++;
    push(cyc + 2, P_PRESS);
    repeat (5) @(negedge c50M);
    chk("midhold_held", 32'(Held), 32'd1);
    #3 nReset = 1'b0;
    #1;
    chk("midhold_reset_outputs", {23'd0, Held, PressPulse, ReleasePulse, ClickPulse, LongPulse,
                                  RepeatPulse, PressCount}, 32'd0);
    @(negedge c50M);
    nReset = 1'b1;
    exp_cnt = 8'd1;
    push(cyc + 2, P_PRESS);
    repeat (4) @(negedge c50M);
    ButtonIn = 1'b0;
    push(cyc + 2, P_REL | P_CLICK);
    drain("post_reset_drain");
    chk("post_reset_count", 32'(PressCount), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_press_decoder.md
Name: button_press_decoder

Overview:
- Sits directly downstream of the hardware button debouncer. Consumes its clean, active-high level ButtonOut.
- Converts the level into single-cycle event pulses: press, release, short click, long press and auto-repeat.
- Keeps a wrapping count of presses for the FPGA control logic.
- Same 50 MHz domain as the debouncer, so the input needs no extra synchronizer.

Parameters:
- LONG_CYCLES, 25000000: hold time in clock cycles from the press pulse to the long_press pulse (0.5 s at 50 MHz). Legal range 2..2^CNT_W-1.
- REPEAT_CYCLES, 5000000: period in cycles between auto-repeat pulses once a long press has fired. Legal range 2..2^CNT_W-1.
- CNT_W, 26: width of the hold/repeat counter.

Ports:
- c50M  input  1  50 MHz system clock; all logic on rising edge.
- nReset  input  1  asynchronous active-low reset. Asserts immediately; its release is used synchronously to c50M.
- ButtonIn  input  1  debounced button level, 1 = pressed.
- Held  output  1  level, 1 while the decoder is in any pressed state.
- PressPulse  output  1  one-cycle pulse on press.
- ReleasePulse  output  1  one-cycle pulse on release.
- ClickPulse  output  1  one-cycle pulse on release of a short press.
- LongPulse  output  1  one-cycle pulse when the hold reaches LONG_CYCLES.
- RepeatPulse  output  1  one-cycle auto-repeat pulse (see Optional Feature).
- PressCount  output  8  number of presses, wraps 255 -> 0.

Behaviour:
- Reset (nReset = 0): state = IDLE, counter = 0, every output = 0 including PressCount, registered input sample btn_q = 0.
- All outputs are registered; no combinational path from ButtonIn to any output.
- btn_q samples ButtonIn every cycle. FSM decisions use btn_q, so a rise on ButtonIn at edge N is seen by btn_q at N and acted on at N+1.
- States: IDLE, SHORT, LONG.
- IDLE, btn_q = 1:
  - go to SHORT; PressPulse = 1 for one cycle; Held = 1.
  - PressCount += 1, mod 256, updated in the same cycle as PressPulse.
  - counter = 1.
- SHORT, btn_q = 1:
  - counter increments.
  - When counter == LONG_CYCLES: go to LONG, LongPulse = 1 for one cycle, counter = 1.
  - Net effect: LongPulse rises exactly LONG_CYCLES cycles after PressPulse.
- SHORT, btn_q = 0: go to IDLE; ReleasePulse = 1 and ClickPulse = 1 in the same cycle; Held = 0; counter = 0.
- LONG, btn_q = 1: counter increments; RepeatPulse behaviour per Optional Feature.
- LONG, btn_q = 0: go to IDLE; ReleasePulse = 1; ClickPulse stays 0; Held = 0; counter = 0.
- Simultaneous release and threshold (btn_q = 0 in the cycle the counter would hit LONG_CYCLES or a repeat point): release wins. No LongPulse and no RepeatPulse; ClickPulse follows the state held before the release.
- Minimum press: ButtonIn high for a single cycle still yields PressPulse, then ReleasePulse + ClickPulse exactly 1 cycle later.
- Press immediately after release: IDLE with btn_q = 1 in the cycle after ReleasePulse gives PressPulse next cycle. No dead time.
- Counter saturation: the counter cannot exceed max(LONG_CYCLES, REPEAT_CYCLES), so it never wraps. Indefinite holds in LONG are safe.
- Reset mid-hold: all pulses cease at once and Held = 0. After reset is released with ButtonIn still high, a fresh PressPulse is issued (counted as a new press).
- At most one of PressPulse/LongPulse/RepeatPulse is high in any cycle. ReleasePulse and ClickPulse may coincide.

Optional Feature:
- Macro: BTN_DECODER_REPEAT_EN.
- Defined: in LONG with btn_q = 1, when counter == REPEAT_CYCLES, RepeatPulse = 1 for one cycle and counter = 1. The first RepeatPulse is REPEAT_CYCLES cycles after LongPulse, then every REPEAT_CYCLES cycles until release.
- Not defined: RepeatPulse tied to 0; the counter stops incrementing in LONG; no repeat compare logic is synthesized. All other behaviour is unchanged.

Test Plan:
- Bench parameters for all scenarios: LONG_CYCLES = 10, REPEAT_CYCLES = 4.
- Reset with ButtonIn = 0, then 20 idle cycles -> all outputs 0, PressCount = 0, no pulses.
- ButtonIn high for 3 cycles then low ->
  - PressPulse 2 cycles after the ButtonIn rise; PressCount = 1.
  - ReleasePulse + ClickPulse together 2 cycles after the ButtonIn fall.
  - LongPulse never fires; Held high for exactly 3 cycles.
- ButtonIn held 30 cycles, macro defined -> LongPulse 10 cycles after PressPulse; RepeatPulse at +14, +18, +22, +26; ReleasePulse with no ClickPulse.
- Same 30-cycle hold, macro undefined -> LongPulse at +10, RepeatPulse never asserted.
- Release in the exact cycle btn_q would reach the threshold (ButtonIn high 10 cycles) -> no LongPulse; ReleasePulse + ClickPulse.
- 257 one-cycle presses separated by 1 low cycle -> 257 PressPulses, PressCount = 1 (wrapped). Then assert nReset mid-hold -> outputs 0 immediately, and with ButtonIn still high a new PressPulse follows reset release, PressCount = 1.
